// File: rtl/dpic_mem_arbiter.sv
// Single-port arbiter between instruction fetch and load/store in front of the
// DPI-C memory model; one transaction in flight, LS priority with a starvation guard.
module dpic_mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [63:0] if_req_addr,
  output logic        if_rsp_valid,
  input  logic        if_rsp_ready,
  output logic [63:0] if_rsp_data,
  input  logic        ls_req_valid,
  output logic        ls_req_ready,
  input  logic        ls_req_wen,
  input  logic [63:0] ls_req_addr,
  input  logic [63:0] ls_req_wdata,
  input  logic [7:0]  ls_req_wmask,
  output logic        ls_rsp_valid,
  input  logic        ls_rsp_ready,
  output logic [63:0] ls_rsp_rdata,
  output logic        ls_rsp_err,
  output logic        mem_rd_en,
  output logic [63:0] mem_rd_addr,
  input  logic [63:0] mem_rd_data,
  output logic        mem_we_en,
  output logic [63:0] mem_we_addr,
  output logic [63:0] mem_we_data,
  output logic [7:0]  mem_we_mask
);
  typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, RESP} state_t;
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t      state_q, state_d;
  logic        owner_ls_q, owner_ls_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [7:0]  wmask_q, wmask_d;
  logic [63:0] data_q, data_d;
  logic        err_q, err_d;
  logic [3:0]  starve_q, starve_d;
  logic        if_rsp_valid_q, if_rsp_valid_d;
  logic        ls_rsp_valid_q, ls_rsp_valid_d;
  logic        mem_rd_en_q, mem_rd_en_d;
  logic [63:0] mem_rd_addr_q, mem_rd_addr_d;
  logic        mem_we_en_q, mem_we_en_d;
  logic [63:0] mem_we_addr_q, mem_we_addr_d;
  logic [63:0] mem_we_data_q, mem_we_data_d;
  logic [7:0]  mem_we_mask_q, mem_we_mask_d;
  logic        grant_ls, grant_if, legal_mask, rsp_done;

  always_comb begin
    grant_ls   = ls_req_valid && !(if_req_valid && (starve_q == LIMIT));
    grant_if   = if_req_valid && !grant_ls;
    legal_mask = (ls_req_wmask == 8'h01) || (ls_req_wmask == 8'h03) ||
                 (ls_req_wmask == 8'h0F) || (ls_req_wmask == 8'hFF);
    rsp_done   = owner_ls_q ? ls_rsp_ready : if_rsp_ready;

    state_d    = state_q;
    owner_ls_d = owner_ls_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wmask_d    = wmask_q;
    data_d     = data_q;
    err_d      = err_q;
    starve_d   = starve_q;

    case (state_q)
      IDLE: begin
        if (grant_ls) begin
          owner_ls_d = 1'b1;
          addr_d     = ls_req_addr;
          wdata_d    = ls_req_wdata;
          wmask_d    = ls_req_wmask;
          data_d     = '0;
          err_d      = 1'b0;
          // Only LS grants that make IF wait count toward starvation.
          if (if_req_valid)
            starve_d = (starve_q == LIMIT) ? LIMIT : starve_q + 4'd1;
          else
            starve_d = '0;
          if (!ls_req_wen) begin
            state_d = READ;
          end else if (legal_mask) begin
            state_d = WRITE;
          end else begin
            state_d = RESP;
            err_d   = 1'b1;
          end
        end else if (grant_if) begin
          owner_ls_d = 1'b0;
          addr_d     = if_req_addr;
          data_d     = '0;
          err_d      = 1'b0;
          starve_d   = '0;
          state_d    = READ;
        end
      end
      READ:  state_d = WAIT;
      WAIT: begin
        data_d  = mem_rd_data;
        state_d = RESP;
      end
      WRITE: begin
        data_d  = '0;
        state_d = RESP;
      end
      RESP: if (rsp_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they are glitch-free.
    if_rsp_valid_d = (state_d == RESP) && !owner_ls_d;
    ls_rsp_valid_d = (state_d == RESP) && owner_ls_d;
    mem_rd_en_d    = (state_d == READ);
    mem_rd_addr_d  = mem_rd_en_d ? addr_d : '0;
    mem_we_en_d    = (state_d == WRITE);
    mem_we_addr_d  = mem_we_en_d ? addr_d : '0;
    mem_we_data_d  = mem_we_en_d ? wdata_d : '0;
    mem_we_mask_d  = mem_we_en_d ? wmask_d : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      owner_ls_q     <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      wmask_q        <= '0;
      data_q         <= '0;
      err_q          <= 1'b0;
      starve_q       <= '0;
      if_rsp_valid_q <= 1'b0;
      ls_rsp_valid_q <= 1'b0;
      mem_rd_en_q    <= 1'b0;
      mem_rd_addr_q  <= '0;
      mem_we_en_q    <= 1'b0;
      mem_we_addr_q  <= '0;
      mem_we_data_q  <= '0;
      mem_we_mask_q  <= '0;
    end else begin
      state_q        <= state_d;
      owner_ls_q     <= owner_ls_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      wmask_q        <= wmask_d;
      data_q         <= data_d;
      err_q          <= err_d;
      starve_q       <= starve_d;
      if_rsp_valid_q <= if_rsp_valid_d;
      ls_rsp_valid_q <= ls_rsp_valid_d;
      mem_rd_en_q    <= mem_rd_en_d;
      mem_rd_addr_q  <= mem_rd_addr_d;
      mem_we_en_q    <= mem_we_en_d;
      mem_we_addr_q  <= mem_we_addr_d;
      mem_we_data_q  <= mem_we_data_d;
      mem_we_mask_q  <= mem_we_mask_d;
    end
  end

  assign if_req_ready = (state_q == IDLE) && grant_if;
  assign ls_req_ready = (state_q == IDLE) && grant_ls;
  assign if_rsp_valid = if_rsp_valid_q;
  assign ls_rsp_valid = ls_rsp_valid_q;
  assign if_rsp_data  = data_q;
  assign ls_rsp_rdata = data_q;
  assign ls_rsp_err   = err_q;
  assign mem_rd_en    = mem_rd_en_q;
  assign mem_rd_addr  = mem_rd_addr_q;
  assign mem_we_en    = mem_we_en_q;
  assign mem_we_addr  = mem_we_addr_q;
  assign mem_we_data  = mem_we_data_q;
  assign mem_we_mask  = mem_we_mask_q;
endmodule

// File: tb/tb_dpic_mem_arbiter.sv
// Bench for dpic_mem_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level model of arbitration order, latency and memory contents.
module tb_dpic_mem_arbiter;
  localparam int LIMIT = 4;
  localparam logic [63:0] BASE = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req_valid = 1'b0, if_req_ready;
  logic [63:0] if_req_addr = '0;
  logic        if_rsp_valid, if_rsp_ready = 1'b0;
  logic [63:0] if_rsp_data;
  logic        ls_req_valid = 1'b0, ls_req_ready;
  logic        ls_req_wen = 1'b0;
  logic [63:0] ls_req_addr = '0, ls_req_wdata = '0;
  logic [7:0]  ls_req_wmask = '0;
  logic        ls_rsp_valid, ls_rsp_ready = 1'b0;
  logic [63:0] ls_rsp_rdata;
  logic        ls_rsp_err;
  logic        mem_rd_en, mem_we_en;
  logic [63:0] mem_rd_addr, mem_rd_data, mem_we_addr, mem_we_data;
  logic [7:0]  mem_we_mask;

  int n_cmp = 0;
  int n_fail = 0;
  int we_count = 0;

  bit [63:0] env_mem [0:1023];
  bit        env_wr  [0:1023];
  bit [63:0] ref_mem [0:1023];
  bit        ref_wr  [0:1023];

  dpic_mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_ready(if_rsp_ready), .if_rsp_data(if_rsp_data),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_req_wen(ls_req_wen),
    .ls_req_addr(ls_req_addr), .ls_req_wdata(ls_req_wdata), .ls_req_wmask(ls_req_wmask),
    .ls_rsp_valid(ls_rsp_valid), .ls_rsp_ready(ls_rsp_ready), .ls_rsp_rdata(ls_rsp_rdata),
    .ls_rsp_err(ls_rsp_err),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .mem_we_en(mem_we_en), .mem_we_addr(mem_we_addr), .mem_we_data(mem_we_data),
    .mem_we_mask(mem_we_mask)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] init_val(input logic [63:0] a);
    if (a == BASE) return 64'h1122_3344_5566_7788;
    return {a[31:0] ^ 32'hA5A5_5A5A, ~a[31:0]};
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old_v, input logic [63:0] new_v,
                                        input logic [7:0] m);
    logic [63:0] r;
    r = old_v;
    for (int b = 0; b < 8; b++) if (m[b]) r[8*b +: 8] = new_v[8*b +: 8];
    return r;
  endfunction

  function automatic logic [63:0] env_read(input logic [63:0] a);
    return env_wr[a[12:3]] ? env_mem[a[12:3]] : init_val(a);
  endfunction

  function automatic logic [63:0] ref_read(input logic [63:0] a);
    return ref_wr[a[12:3]] ? ref_mem[a[12:3]] : init_val(a);
  endfunction

  task automatic ref_store(input logic [63:0] a, input logic [63:0] d, input logic [7:0] m);
    ref_mem[a[12:3]] = merge(ref_read(a), d, m);
    ref_wr[a[12:3]]  = 1'b1;
  endtask

  // Memory model: registered read, write lands in the cycle we_en is high.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= env_read(mem_rd_addr);
    if (mem_we_en) begin
      env_mem[mem_we_addr[12:3]] <= merge(env_read(mem_we_addr), mem_we_data, mem_we_mask);
      env_wr[mem_we_addr[12:3]]  <= 1'b1;
      we_count <= we_count + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({if_req_ready, ls_req_ready, if_rsp_valid, ls_rsp_valid, ls_rsp_err, mem_rd_en, mem_we_en} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 0000000",
               {if_req_ready, ls_req_ready, if_rsp_valid, ls_rsp_valid, ls_rsp_err, mem_rd_en, mem_we_en});
    end
    n_cmp++;
    if ((if_rsp_data | ls_rsp_rdata | mem_rd_addr | mem_we_addr | mem_we_data | {56'b0, mem_we_mask}) !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_data: got if=%h ls=%h rda=%h wa=%h wd=%h wm=%h expected all 0",
               if_rsp_data, ls_rsp_rdata, mem_rd_addr, mem_we_addr, mem_we_data, mem_we_mask);
    end
    if_req_valid = 1'b1;
    #1;
    n_cmp++;
    if (if_req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_idle: if_req_ready got %b expected 1", if_req_ready);
    end
    if_req_valid = 1'b0;
  endtask

  task automatic test_if_read();
    tick();
    if_req_valid = 1'b1;
    if_req_addr  = BASE;
    #1;
    n_cmp++;
    if ({if_req_ready, ls_req_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL if_read_ready: got %b expected 10", {if_req_ready, ls_req_ready});
    end
    tick();
    if_req_valid = 1'b0;
    n_cmp++;
    if (mem_rd_en !== 1'b1 || mem_rd_addr !== BASE) begin
      n_fail++;
      $display("FAIL if_read_cmd: got en=%b addr=%h expected en=1 addr=%h", mem_rd_en, mem_rd_addr, BASE);
    end
    tick();
    n_cmp++;
    if (mem_rd_en !== 1'b0 || if_rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL if_read_wait: got rd_en=%b rsp_valid=%b expected 0 0", mem_rd_en, if_rsp_valid);
    end
    tick();
    n_cmp++;
    if (if_rsp_valid !== 1'b1 || if_rsp_data !== 64'h1122_3344_5566_7788 || ls_rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL if_read_rsp: got v=%b data=%h lsv=%b expected v=1 data=1122334455667788 lsv=0",
               if_rsp_valid, if_rsp_data, ls_rsp_valid);
    end
    if_rsp_ready = 1'b1;
    tick();
    if_rsp_ready = 1'b0;
    n_cmp++;
    if (if_rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL if_read_done: if_rsp_valid got %b expected 0", if_rsp_valid);
    end
  endtask

  task automatic test_store();
    tick();
    ls_req_valid = 1'b1;
    ls_req_wen   = 1'b1;
    ls_req_addr  = BASE + 64'h1000;
    ls_req_wdata = 64'hDEAD_BEEF;
    ls_req_wmask = 8'h0F;
    #1;
    n_cmp++;
    if ({if_req_ready, ls_req_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL store_ready: got %b expected 01", {if_req_ready, ls_req_ready});
    end
    ref_store(BASE + 64'h1000, 64'hDEAD_BEEF, 8'h0F);
    tick();
    ls_req_valid = 1'b0;
    n_cmp++;
    if (mem_we_en !== 1'b1 || mem_we_addr !== BASE + 64'h1000 || mem_we_data !== 64'hDEAD_BEEF ||
        mem_we_mask !== 8'h0F || mem_rd_en !== 1'b0 || ls_rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL store_cmd: got we=%b a=%h d=%h m=%h rd=%b v=%b expected we=1 a=%h d=deadbeef m=0f rd=0 v=0",
               mem_we_en, mem_we_addr, mem_we_data, mem_we_mask, mem_rd_en, ls_rsp_valid, BASE + 64'h1000);
    end
    tick();
    n_cmp++;
    if (mem_we_en !== 1'b0 || ls_rsp_valid !== 1'b1 || ls_rsp_rdata !== 64'h0 || ls_rsp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL store_rsp: got we=%b v=%b rdata=%h err=%b expected we=0 v=1 rdata=0 err=0",
               mem_we_en, ls_rsp_valid, ls_rsp_rdata, ls_rsp_err);
    end
    ls_rsp_ready = 1'b1;
    tick();
    ls_rsp_ready = 1'b0;
  endtask

  task automatic test_illegal_mask();
    int we_before;
    tick();
    we_before    = we_count;
    ls_req_valid = 1'b1;
    ls_req_wen   = 1'b1;
    ls_req_addr  = BASE + 64'h8;
    ls_req_wdata = 64'hCAFE_F00D_1234_5678;
    ls_req_wmask = 8'h05;
    tick();
    ls_req_valid = 1'b0;
    n_cmp++;
    if (ls_rsp_valid !== 1'b1 || ls_rsp_err !== 1'b1 || ls_rsp_rdata !== 64'h0 || mem_we_en !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_rsp: got v=%b err=%b rdata=%h we=%b expected v=1 err=1 rdata=0 we=0",
               ls_rsp_valid, ls_rsp_err, ls_rsp_rdata, mem_we_en);
    end
    ls_rsp_ready = 1'b1;
    tick();
    ls_rsp_ready = 1'b0;
    tick();
    n_cmp++;
    if (we_count !== we_before) begin
      n_fail++;
      $display("FAIL illegal_nowrite: write count got %0d expected %0d", we_count, we_before);
    end
  endtask

  task automatic test_starvation();
    int g;
    bit got_ls;
    g = 0;
    tick();
    if_req_valid = 1'b1;
    if_req_addr  = BASE + 64'h20;
    ls_req_valid = 1'b1;
    ls_req_wen   = 1'b0;
    ls_req_addr  = BASE + 64'h18;
    if_rsp_ready = 1'b1;
    ls_rsp_ready = 1'b1;
    for (int cyc = 0; cyc < 200 && g < 10; cyc++) begin
      #1;
      if (if_req_ready || ls_req_ready) begin
        got_ls = ls_req_ready;
        n_cmp++;
        if (got_ls !== ((g % 5) != 4)) begin
          n_fail++;
          $display("FAIL starve_order grant %0d: got %s expected %s", g,
                   got_ls ? "LS" : "IF", ((g % 5) != 4) ? "LS" : "IF");
        end
        g++;
      end
      tick();
    end
    if_req_valid = 1'b0;
    ls_req_valid = 1'b0;
    n_cmp++;
    if (g != 10) begin
      n_fail++;
      $display("FAIL starve_timeout: grants got %0d expected 10", g);
    end
    repeat (6) tick();
    if_rsp_ready = 1'b0;
    ls_rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [63:0] exp_d;
    int lat;
    tick();
    exp_d        = ref_read(BASE + 64'h10);
    if_req_valid = 1'b1;
    if_req_addr  = BASE + 64'h28;
    ls_req_valid = 1'b1;
    ls_req_wen   = 1'b0;
    ls_req_addr  = BASE + 64'h10;
    tick();
    ls_req_valid = 1'b0;
    lat = 1;
    while (!ls_rsp_valid && lat < 8) begin
      tick();
      lat++;
    end
    n_cmp++;
    if (lat != 3) begin
      n_fail++;
      $display("FAIL bp_latency: got %0d expected 3", lat);
    end
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if (ls_rsp_valid !== 1'b1 || ls_rsp_rdata !== exp_d || if_req_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold cycle %0d: got v=%b rdata=%h if_ready=%b expected v=1 rdata=%h if_ready=0",
                 i, ls_rsp_valid, ls_rsp_rdata, if_req_ready, exp_d);
      end
      tick();
    end
    ls_rsp_ready = 1'b1;
    tick();
    ls_rsp_ready = 1'b0;
    n_cmp++;
    if (if_req_ready !== 1'b1 || ls_rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release: got if_ready=%b ls_v=%b expected 1 0", if_req_ready, ls_rsp_valid);
    end
    tick();
    if_req_valid = 1'b0;
    n_cmp++;
    if (mem_rd_en !== 1'b1 || mem_rd_addr !== BASE + 64'h28) begin
      n_fail++;
      $display("FAIL bp_if_cmd: got en=%b addr=%h expected en=1 addr=%h", mem_rd_en, mem_rd_addr, BASE + 64'h28);
    end
    if_rsp_ready = 1'b1;
    repeat (3) tick();
    if_rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n;
    // Part A: reset during WAIT of an IF read drops the response.
    tick();
    if_req_valid = 1'b1;
    if_req_addr  = BASE + 64'h30;
    tick();
    if_req_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (if_rsp_valid !== 1'b0 || mem_rd_en !== 1'b0 || mem_we_en !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_mid cycle %0d: got rsp_v=%b rd=%b we=%b expected 0 0 0",
                 i, if_rsp_valid, mem_rd_en, mem_we_en);
      end
      tick();
    end
    // Part B: saturate the starvation count, then reset; LS must win again.
    n = 0;
    if_req_valid = 1'b1;
    if_req_addr  = BASE + 64'h38;
    ls_req_valid = 1'b1;
    ls_req_wen   = 1'b0;
    ls_req_addr  = BASE;
    ls_rsp_ready = 1'b1;
    if_rsp_ready = 1'b1;
    for (int cyc = 0; cyc < 60 && n < 4; cyc++) begin
      #1;
      if (ls_req_ready) n++;
      tick();
    end
    n_cmp++;
    if (n != 4) begin
      n_fail++;
      $display("FAIL reset_starve_setup: LS grants got %0d expected 4", n);
    end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({if_req_ready, ls_req_ready} !== 2'b01 || mem_rd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_starve_clear: got ready=%b rd=%b expected ready=01 rd=0",
               {if_req_ready, ls_req_ready}, mem_rd_en);
    end
    if_req_valid = 1'b0;
    ls_req_valid = 1'b0;
    ls_rsp_ready = 1'b0;
    if_rsp_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [7:0] mask_tab [0:5];
    bit          if_pend, ls_pend, ls_wen_p, exp_ls, exp_err;
    logic [63:0] if_addr_p, ls_addr_p, ls_wdata_p, exp_d, got_d;
    logic [7:0]  ls_mask_p;
    int          mcnt, exp_lat, lat;
    mask_tab = '{8'h01, 8'h03, 8'h0F, 8'hFF, 8'h05, 8'h80};
    if_pend = 1'b0;
    ls_pend = 1'b0;
    mcnt    = 0;
    if_addr_p = '0; ls_addr_p = '0; ls_wdata_p = '0; ls_mask_p = '0; ls_wen_p = 1'b0;
    tick();
    for (int t = 0; t < 150; t++) begin
      if (!if_pend && $urandom_range(0, 1) == 1) begin
        if_pend   = 1'b1;
        if_addr_p = BASE + 64'($urandom_range(0, 7)) * 8;
      end
      if (!ls_pend && $urandom_range(0, 2) != 0) begin
        ls_pend    = 1'b1;
        ls_wen_p   = $urandom_range(0, 1) == 1;
        ls_addr_p  = BASE + 64'($urandom_range(0, 7)) * 8;
        ls_wdata_p = {$urandom, $urandom};
        ls_mask_p  = mask_tab[$urandom_range(0, 5)];
      end
      if (!if_pend && !ls_pend) begin
        if_pend   = 1'b1;
        if_addr_p = BASE + 64'($urandom_range(0, 7)) * 8;
      end
      if_req_valid = if_pend;
      if_req_addr  = if_addr_p;
      ls_req_valid = ls_pend;
      ls_req_wen   = ls_wen_p;
      ls_req_addr  = ls_addr_p;
      ls_req_wdata = ls_wdata_p;
      ls_req_wmask = ls_mask_p;
      #1;
      // Reference: LS first, unless IF has already waited through LIMIT LS grants.
      exp_ls = ls_pend && !(if_pend && mcnt == LIMIT);
      n_cmp++;
      if ({if_req_ready, ls_req_ready} !== {!exp_ls, exp_ls}) begin
        n_fail++;
        $display("FAIL rnd_grant txn %0d: got ready=%b expected %b", t,
                 {if_req_ready, ls_req_ready}, {!exp_ls, exp_ls});
      end
      exp_err = 1'b0;
      if (exp_ls) begin
        mcnt = if_pend ? ((mcnt == LIMIT) ? LIMIT : mcnt + 1) : 0;
        if (!ls_wen_p) begin
          exp_d = ref_read(ls_addr_p);
          exp_lat = 3;
        end else if (ls_mask_p inside {8'h01, 8'h03, 8'h0F, 8'hFF}) begin
          ref_store(ls_addr_p, ls_wdata_p, ls_mask_p);
          exp_d = '0;
          exp_lat = 2;
        end else begin
          exp_d = '0;
          exp_err = 1'b1;
          exp_lat = 1;
        end
      end else begin
        mcnt = 0;
        exp_d = ref_read(if_addr_p);
        exp_lat = 3;
      end
      $display("txn %0d %s wen=%0b addr=%h mask=%h exp_data=%h exp_err=%0b", t,
               exp_ls ? "LS" : "IF", exp_ls && ls_wen_p, exp_ls ? ls_addr_p : if_addr_p,
               exp_ls ? ls_mask_p : 8'h00, exp_d, exp_err);
      tick();
      if (exp_ls) ls_pend = 1'b0; else if_pend = 1'b0;
      if_req_valid = if_pend;
      ls_req_valid = ls_pend;
      lat = 1;
      while (!(exp_ls ? ls_rsp_valid : if_rsp_valid) && lat < 8) begin
        tick();
        lat++;
      end
      n_cmp++;
      if (lat != exp_lat || (exp_ls ? if_rsp_valid : ls_rsp_valid) !== 1'b0) begin
        n_fail++;
        $display("FAIL rnd_latency txn %0d: got %0d expected %0d (other valid=%b)", t, lat, exp_lat,
                 exp_ls ? if_rsp_valid : ls_rsp_valid);
      end
      repeat ($urandom_range(0, 2)) tick();
      got_d = exp_ls ? ls_rsp_rdata : if_rsp_data;
      n_cmp++;
      if (got_d !== exp_d || (exp_ls && ls_rsp_err !== exp_err)) begin
        n_fail++;
        $display("FAIL rnd_data txn %0d: got data=%h err=%b expected data=%h err=%b", t,
                 got_d, ls_rsp_err, exp_d, exp_err);
      end
      if (exp_ls) ls_rsp_ready = 1'b1; else if_rsp_ready = 1'b1;
      tick();
      ls_rsp_ready = 1'b0;
      if_rsp_ready = 1'b0;
    end
    if_req_valid = 1'b0;
    ls_req_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_if_read();
    test_store();
    test_illegal_mask();
    test_starvation();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
